// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall / flush / redirect controller for a 5-stage pipeline.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   stallreq_if/id/ex/mem  per-stage stall requests (deepest one wins)
//   mc_start, mc_lat  EX multi-cycle op launch pulse and its latency N
//   exc_req           MEM-stage exception, exc_vector is the handler PC
//   if_ready          IF accepts the pending redirect this cycle
//   en[4:0]           register enables: pc, if_id, id_ex, ex_mem, mem_wb
//   flush[4:0]        per-register bubble insert, same bit order
//   mc_busy           multi-cycle op is holding EX this cycle
//   redirect_valid    PC redirect pending
//   redirect_pc       redirect target
//
// Priority of the enable/flush decode: rst > exc_req > REDIRECT > stalls.
// mc_busy includes the launch cycle (the cycle mc_start is accepted), so it
// is high for exactly the N cycles the internal EX stall is asserted.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        mc_start,
  input  logic [5:0]  mc_lat,
  input  logic        exc_req,
  input  logic [31:0] exc_vector,
  input  logic        if_ready,
  output logic [4:0]  en,
  output logic [4:0]  flush,
  output logic        mc_busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MC_WAIT  = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  logic [1:0] state_p0;
  logic [5:0] mc_cnt_p0;
  logic       mc_accept;
  logic       mc_stall;
  logic [3:0] stall_vec;

  // A launch is only honoured from RUN with a non-zero latency; an exception
  // in the same cycle wins and the op never starts.
  assign mc_accept = (state_p0 == ST_RUN) && mc_start && (mc_lat != 6'd0) && !exc_req;
  assign mc_stall  = (state_p0 == ST_MC_WAIT) || mc_accept;

  // Bit index equals stage number: IF=0, ID=1, EX=2, MEM=3.
  assign stall_vec = {stallreq_mem, stallreq_ex | mc_stall, stallreq_id, stallreq_if};

  always_comb begin
    en    = 5'b11111;
    flush = 5'b00000;
    if (rst) begin
      en    = 5'b00000;
      flush = 5'b11111;
    end else if (exc_req) begin
      en    = 5'b11110;
      flush = 5'b11110;
    end else if (state_p0 == ST_REDIRECT) begin
      en    = {4'b1111, if_ready};
      flush = 5'b11110;
    end else begin
      // Hold everything up to the deepest stalled stage, bubble the next one.
      casez (stall_vec)
        4'b1???: begin en = 5'b10000; flush = 5'b10000; end
        4'b01??: begin en = 5'b11000; flush = 5'b01000; end
        4'b001?: begin en = 5'b11100; flush = 5'b00100; end
        4'b0001: begin en = 5'b11110; flush = 5'b00010; end
        default: begin en = 5'b11111; flush = 5'b00000; end
      endcase
    end
  end

  // ---- stage p0: control state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0    <= ST_RUN;
      mc_cnt_p0   <= 6'd0;
      redirect_pc <= 32'h0;
    end else if (exc_req) begin
      // Exceptions abort any multi-cycle op and (re)arm the redirect,
      // even if IF is accepting an older redirect this very cycle.
      state_p0    <= ST_REDIRECT;
      mc_cnt_p0   <= 6'd0;
      redirect_pc <= exc_vector;
    end else begin
      case (state_p0)
        ST_RUN: begin
          // N=1 stalls only the launch cycle and never leaves RUN.
          if (mc_accept && (mc_lat != 6'd1)) begin
            state_p0  <= ST_MC_WAIT;
            mc_cnt_p0 <= mc_lat - 6'd1;
          end
        end
        ST_MC_WAIT: begin
          // Counts down unconditionally; a MEM stall does not extend the op.
          mc_cnt_p0 <= mc_cnt_p0 - 6'd1;
          if (mc_cnt_p0 <= 6'd1) begin
            state_p0  <= ST_RUN;
            mc_cnt_p0 <= 6'd0;
          end
        end
        ST_REDIRECT: begin
          if (if_ready) state_p0 <= ST_RUN;
        end
        default: begin
          state_p0  <= ST_RUN;
          mc_cnt_p0 <= 6'd0;
        end
      endcase
    end
  end

  assign mc_busy        = !rst && mc_stall;
  assign redirect_valid = !rst && (state_p0 == ST_REDIRECT);

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        mc_start;
  logic [5:0]  mc_lat;
  logic        exc_req;
  logic [31:0] exc_vector;
  logic        if_ready;
  logic [4:0]  en, flush;
  logic        mc_busy, redirect_valid;
  logic [31:0] redirect_pc;

  int n_vec  = 0;
  int n_fail = 0;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .mc_start(mc_start), .mc_lat(mc_lat),
    .exc_req(exc_req), .exc_vector(exc_vector), .if_ready(if_ready),
    .en(en), .flush(flush), .mc_busy(mc_busy),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Inputs are driven just after a falling edge, outputs checked 1 time unit
  // later, well before the next rising edge.
  task automatic idle_inputs();
    rst = 0; stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    mc_start = 0; mc_lat = 6'd0; exc_req = 0; exc_vector = 32'h0; if_ready = 0;
  endtask

  // expected vector = {en, flush, mc_busy, redirect_valid}
  task automatic test_reset();
    logic [11:0] got;
    idle_inputs();
    rst = 1; stallreq_id = 1; mc_start = 1; mc_lat = 6'd5; exc_req = 1; exc_vector = 32'hDEADBEEF;
    for (int c = 0; c < 2; c++) begin
      #1;
      got = {en, flush, mc_busy, redirect_valid};
      n_vec++;
      if (got !== 12'b00000_11111_0_0) begin
        n_fail++;
        $display("FAIL reset c%0d: got %b, expected %b", c, got, 12'b00000_11111_0_0);
      end
      if (c == 1) begin
        n_vec++;
        if (redirect_pc !== 32'h0) begin
          n_fail++;
          $display("FAIL reset_pc: got %h, expected %h", redirect_pc, 32'h0);
        end
      end
      @(negedge clk);
    end
    idle_inputs();
    #1;
    got = {en, flush, mc_busy, redirect_valid};
    n_vec++;
    if (got !== 12'b11111_00000_0_0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b, expected %b", got, 12'b11111_00000_0_0);
    end
    @(negedge clk);
  endtask

  task automatic test_stalls();
    // {if,id,ex,mem} -> {en,flush}
    logic [3:0] req [0:6];
    logic [9:0] exp [0:6];
    logic [9:0] got;
    req = '{4'b0100, 4'b1000, 4'b0010, 4'b0001, 4'b1001, 4'b0110, 4'b0000};
    exp = '{10'b11100_00100, 10'b11110_00010, 10'b11000_01000, 10'b10000_10000,
            10'b10000_10000, 10'b11000_01000, 10'b11111_00000};
    for (int i = 0; i < 7; i++) begin
      idle_inputs();
      {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem} = req[i];
      #1;
      got = {en, flush};
      n_vec++;
      if (got !== exp[i] || mc_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_%b: got en/flush=%b busy=%b, expected %b busy=0", req[i], got, mc_busy, exp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_multicycle();
    logic [11:0] exp [0:5];
    logic [11:0] got;
    // lat=4, repeated start at c1 must be ignored, MEM stall at c2 must not extend
    exp = '{12'b11000_01000_1_0, 12'b11000_01000_1_0, 12'b10000_10000_1_0,
            12'b11000_01000_1_0, 12'b11111_00000_0_0, 12'b11111_00000_0_0};
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      mc_start = (c <= 1); mc_lat = 6'd4; stallreq_mem = (c == 2);
      #1;
      got = {en, flush, mc_busy, redirect_valid};
      n_vec++;
      if (got !== exp[c]) begin
        n_fail++;
        $display("FAIL mc_lat4 c%0d: got %b, expected %b", c, got, exp[c]);
      end
      @(negedge clk);
    end
    // lat=0 ignored
    idle_inputs(); mc_start = 1; mc_lat = 6'd0;
    #1;
    got = {en, flush, mc_busy, redirect_valid};
    n_vec++;
    if (got !== 12'b11111_00000_0_0) begin
      n_fail++;
      $display("FAIL mc_lat0: got %b, expected %b", got, 12'b11111_00000_0_0);
    end
    @(negedge clk);
    // lat=1: one stall cycle only
    for (int c = 0; c < 2; c++) begin
      idle_inputs(); mc_start = (c == 0); mc_lat = 6'd1;
      #1;
      got = {en, flush, mc_busy, redirect_valid};
      n_vec++;
      if (got !== ((c == 0) ? 12'b11000_01000_1_0 : 12'b11111_00000_0_0)) begin
        n_fail++;
        $display("FAIL mc_lat1 c%0d: got %b, expected %b", c, got,
                 (c == 0) ? 12'b11000_01000_1_0 : 12'b11111_00000_0_0);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_exception();
    logic [11:0] exp [0:7];
    logic [11:0] got;
    exp = '{12'b11000_01000_1_0, 12'b11000_01000_1_0, 12'b11110_11110_1_0,
            12'b11110_11110_0_1, 12'b11110_11110_0_1, 12'b11110_11110_0_1,
            12'b11111_11110_0_1, 12'b11111_00000_0_0};
    for (int c = 0; c < 8; c++) begin
      idle_inputs();
      mc_start = (c == 0); mc_lat = 6'd10;
      exc_req = (c == 2); exc_vector = (c == 2) ? 32'hBFC00380 : 32'h0;
      stallreq_id = (c == 4); stallreq_mem = (c == 5);
      if_ready = (c == 6);
      #1;
      got = {en, flush, mc_busy, redirect_valid};
      n_vec++;
      if (got !== exp[c]) begin
        n_fail++;
        $display("FAIL exc_mc c%0d: got %b, expected %b", c, got, exp[c]);
      end
      if (c >= 3 && c <= 6) begin
        n_vec++;
        if (redirect_pc !== 32'hBFC00380) begin
          n_fail++;
          $display("FAIL exc_pc c%0d: got %h, expected %h", c, redirect_pc, 32'hBFC00380);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back_exc();
    logic [11:0] exp [0:4];
    logic [31:0] pc_exp [0:4];
    logic [11:0] got;
    exp = '{12'b11110_11110_0_0, 12'b11110_11110_0_1, 12'b11110_11110_0_1,
            12'b11111_11110_0_1, 12'b11111_00000_0_0};
    pc_exp = '{32'h0, 32'h80000180, 32'h12345678, 32'h12345678, 32'h12345678};
    for (int c = 0; c < 5; c++) begin
      idle_inputs();
      exc_req = (c <= 1);
      exc_vector = (c == 0) ? 32'h80000180 : 32'h12345678;
      if_ready = (c == 1) || (c == 3);
      #1;
      got = {en, flush, mc_busy, redirect_valid};
      n_vec++;
      if (got !== exp[c]) begin
        n_fail++;
        $display("FAIL exc_b2b c%0d: got %b, expected %b", c, got, exp[c]);
      end
      if (c >= 1) begin
        n_vec++;
        if (redirect_pc !== pc_exp[c]) begin
          n_fail++;
          $display("FAIL exc_b2b_pc c%0d: got %h, expected %h", c, redirect_pc, pc_exp[c]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midop();
    logic [11:0] exp [0:6];
    logic [11:0] got;
    exp = '{12'b11000_01000_1_0, 12'b11000_01000_1_0, 12'b00000_11111_0_0,
            12'b11111_00000_0_0, 12'b11110_11110_0_0, 12'b00000_11111_0_0,
            12'b11111_00000_0_0};
    for (int c = 0; c < 7; c++) begin
      idle_inputs();
      mc_start = (c == 0); mc_lat = 6'd8;
      rst = (c == 2) || (c == 5);
      exc_req = (c == 4); exc_vector = 32'hA5A5A5A5;
      #1;
      got = {en, flush, mc_busy, redirect_valid};
      n_vec++;
      if (got !== exp[c]) begin
        n_fail++;
        $display("FAIL rst_mid c%0d: got %b, expected %b", c, got, exp[c]);
      end
      if (c == 6) begin
        n_vec++;
        if (redirect_pc !== 32'h0) begin
          n_fail++;
          $display("FAIL rst_mid_pc: got %h, expected %h", redirect_pc, 32'h0);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_stalls();
    test_multicycle();
    test_exception();
    test_back_to_back_exc();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
